// File: rtl/ysyx_24100012_mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, master ids
// and the byte-count encodings carried on the len fields.
package ysyx_24100012_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } master_id_e;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // The requester that was not granted last; used to break ties.
    function automatic master_id_e other_master(input master_id_e id);
        return (id == MID_M0) ? MID_M1 : MID_M0;
    endfunction

endpackage

// File: rtl/ysyx_24100012_mem_arbiter_if.sv
// Bus bundle between the fetch master (m0), the load-store master (m1),
// the arbiter and the downstream memory.
//
// Handshakes: a request is accepted in the cycle where the requester's
// req_valid is high and the arbiter's req_ready pulses (ready is a one-cycle
// accept pulse, valid may be held). Downstream, a request transfers on the
// rising edge where mem_req_valid and mem_req_ready are both high; the
// arbiter keeps its fields stable until then. Responses (mem_resp_valid,
// m*_resp_valid) are single-cycle pulses with no back-pressure.
interface ysyx_24100012_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req_valid;
    logic                  m0_req_ready;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_resp_valid;
    logic                  m0_resp_err;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req_valid;
    logic                  m1_req_ready;
    logic                  m1_wen;
    logic [2:0]            m1_len;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_resp_valid;
    logic                  m1_resp_err;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_wen;
    logic [2:0]            mem_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  m0_req_valid, m0_addr,
        input  m1_req_valid, m1_wen, m1_len, m1_addr, m1_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output m0_req_ready, m0_resp_valid, m0_resp_err, m0_rdata,
        output m1_req_ready, m1_resp_valid, m1_resp_err, m1_rdata,
        output mem_req_valid, mem_wen, mem_len, mem_addr, mem_wdata
    );

    // Requesters plus memory, i.e. everything around the arbiter.
    modport master (
        output m0_req_valid, m0_addr,
        output m1_req_valid, m1_wen, m1_len, m1_addr, m1_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  m0_req_ready, m0_resp_valid, m0_resp_err, m0_rdata,
        input  m1_req_ready, m1_resp_valid, m1_resp_err, m1_rdata,
        input  mem_req_valid, mem_wen, mem_len, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ysyx_24100012_mem_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module ysyx_24100012_arb_rr
    import ysyx_24100012_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  master_id_e last_grant,
    output master_id_e grant
);

    // Pick the winner; with no request the result is unused.
    always_comb begin
        grant = MID_M0;
        if (valid0 && valid1) begin
            grant = other_master(last_grant);
        end else if (valid1) begin
            grant = MID_M1;
        end
    end

endmodule

// File: rtl/ysyx_24100012_mem_arbiter.sv
// Two-master memory arbiter (fetch m0, load-store m1) in front of a single
// downstream port, one transaction outstanding at a time.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that
// ends a stuck transaction with resp_err after TIMEOUT_CYCLES cycles.
module ysyx_24100012_mem_arbiter
    import ysyx_24100012_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    ysyx_24100012_mem_arbiter_if.slave       bus,
    output arb_state_e                       dbg_state
);

    arb_state_e            state;
    master_id_e            last_grant;
    master_id_e            gnt_id;
    master_id_e            rr_grant;
    logic                  lat_wen;
    logic [2:0]            lat_len;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  m0_rv, m1_rv;
    logic [DATA_WIDTH-1:0] m0_rd, m1_rd;
    logic                  resp_pulse;
    logic                  accept;

    ysyx_24100012_arb_rr u_rr (
        .valid0     (bus.m0_req_valid),
        .valid1     (bus.m1_req_valid),
        .last_grant (last_grant),
        .grant      (rr_grant)
    );

    // No grant while a response pulse is on the outputs, nor in reset.
    assign resp_pulse = m0_rv | m1_rv;
    assign accept     = rst && (state == ST_IDLE) && !resp_pulse &&
                        (bus.m0_req_valid || bus.m1_req_valid);

    assign bus.m0_req_ready  = accept && (rr_grant == MID_M0);
    assign bus.m1_req_ready  = accept && (rr_grant == MID_M1);
    assign bus.m0_resp_valid = m0_rv;
    assign bus.m1_resp_valid = m1_rv;
    assign bus.m0_rdata      = m0_rd;
    assign bus.m1_rdata      = m1_rd;
    assign bus.mem_req_valid = (state == ST_REQ);
    assign bus.mem_wen       = lat_wen;
    assign bus.mem_len       = lat_len;
    assign bus.mem_addr      = lat_addr;
    assign bus.mem_wdata     = lat_wdata;
    assign dbg_state         = state;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic        m0_err, m1_err;
    logic [31:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit         = (tmo_cnt == TMO_LAST);
    assign bus.m0_resp_err = m0_err;
    assign bus.m1_resp_err = m1_err;
`else
    assign bus.m0_resp_err = 1'b0;
    assign bus.m1_resp_err = 1'b0;
`endif

    // Arbitration FSM: grant and latch in IDLE, present in REQ, collect in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= MID_M0;
            gnt_id     <= MID_M0;
            lat_wen    <= 1'b0;
            lat_len    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rv      <= 1'b0;
            m1_rv      <= 1'b0;
            m0_rd      <= '0;
            m1_rd      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            m0_rv <= 1'b0;
            m1_rv <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            m0_err <= 1'b0;
            m1_err <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_id     <= rr_grant;
                        last_grant <= rr_grant;
                        state      <= ST_REQ;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                        if (rr_grant == MID_M0) begin
                            lat_wen   <= 1'b0;
                            lat_len   <= LEN_WORD;
                            lat_addr  <= bus.m0_addr;
                            lat_wdata <= '0;
                        end else begin
                            lat_wen   <= bus.m1_wen;
                            lat_len   <= bus.m1_len;
                            lat_addr  <= bus.m1_addr;
                            lat_wdata <= bus.m1_wdata;
                        end
                    end
                end
                ST_REQ: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    if (tmo_hit) begin
                        state <= ST_IDLE;
                        if (gnt_id == MID_M0) begin
                            m0_rv  <= 1'b1;
                            m0_err <= 1'b1;
                            m0_rd  <= '0;
                        end else begin
                            m1_rv  <= 1'b1;
                            m1_err <= 1'b1;
                            m1_rd  <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (bus.mem_req_ready) begin
                            state <= ST_WAIT;
                        end
                    end
`else
                    if (bus.mem_req_ready) begin
                        state <= ST_WAIT;
                    end
`endif
                end
                ST_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state <= ST_IDLE;
                        if (gnt_id == MID_M0) begin
                            m0_rv <= 1'b1;
                            m0_rd <= bus.mem_rdata;
                        end else begin
                            m1_rv <= 1'b1;
                            m1_rd <= bus.mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= ST_IDLE;
                        if (gnt_id == MID_M0) begin
                            m0_rv  <= 1'b1;
                            m0_err <= 1'b1;
                            m0_rd  <= '0;
                        end else begin
                            m1_rv  <= 1'b1;
                            m1_err <= 1'b1;
                            m1_rd  <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Self-checking bench for ysyx_24100012_mem_arbiter: a vector table of
// single transactions, then round-robin, reset-in-flight and (with
// MEM_ARB_TIMEOUT_EN) watchdog sequences.
module tb_ysyx_24100012_mem_arbiter;
    import ysyx_24100012_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk;
    logic       rst;
    arb_state_e dbg_state;

    ysyx_24100012_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_24100012_mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "time limit reached");
    end

    typedef struct {
        int          m;
        logic        wen;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          resp_dly;
    } vec_t;

    int          checks;
    int          errors;
    logic [DW-1:0] exp_q[$];
    int          exp_m_q[$];
    logic [31:0] last_m0_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.m0_req_ready, bus.m0_resp_valid, bus.m0_resp_err,
                                bus.m1_req_ready, bus.m1_resp_valid, bus.m1_resp_err,
                                bus.mem_req_valid, bus.mem_wen, bus.mem_len}), 64'd0);
        chk({tag, "_m0_rdata"}, 64'(bus.m0_rdata), 64'd0);
        chk({tag, "_m1_rdata"}, 64'(bus.m1_rdata), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive one request, play the memory with the vector's delays, and
    // check fields, latency and the scoreboarded response.
    task automatic run_txn(input int idx, input vec_t v);
        bit          got;
        int          cyc;
        int          act_m;
        logic [31:0] exp_d;
        int          exp_m;
        @(negedge clk);
        if (v.m == 0) begin
            bus.m0_req_valid = 1'b1;
            bus.m0_addr      = v.addr;
            bus.m1_wen       = 1'($urandom_range(0, 1));
            bus.m1_addr      = $urandom;
            bus.m1_wdata     = $urandom;
        end else begin
            bus.m1_req_valid = 1'b1;
            bus.m1_wen       = v.wen;
            bus.m1_len       = v.len;
            bus.m1_addr      = v.addr;
            bus.m1_wdata     = v.wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            got = (v.m == 0) ? bus.m0_req_ready : bus.m1_req_ready;
            @(negedge clk);
        end
        chk($sformatf("v%0d_accept", idx), 64'(got), 64'd1);
        bus.m0_req_valid = 1'b0;
        bus.m1_req_valid = 1'b0;
        if (!got) return;
        cyc = 1;
        for (int k = 0; k <= v.rdy_dly; k++) begin
            #1;
            chk($sformatf("v%0d_c%0d_mem_req_valid", idx, k), 64'(bus.mem_req_valid), 64'd1);
            chk($sformatf("v%0d_c%0d_mem_wen", idx, k), 64'(bus.mem_wen), 64'((v.m == 0) ? 1'b0 : v.wen));
            chk($sformatf("v%0d_c%0d_mem_len", idx, k), 64'(bus.mem_len), 64'((v.m == 0) ? 3'd4 : v.len));
            chk($sformatf("v%0d_c%0d_mem_addr", idx, k), 64'(bus.mem_addr), 64'(v.addr));
            chk($sformatf("v%0d_c%0d_mem_wdata", idx, k), 64'(bus.mem_wdata), 64'((v.m == 0) ? 32'd0 : v.wdata));
            bus.mem_req_ready = (k == v.rdy_dly);
            @(negedge clk);
            cyc++;
        end
        bus.mem_req_ready = 1'b0;
        repeat (v.resp_dly) begin
            @(negedge clk);
            cyc++;
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = v.rdata;
        exp_q.push_back(v.rdata);
        exp_m_q.push_back(v.m);
        @(negedge clk);
        cyc++;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = $urandom;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (bus.m0_resp_valid || bus.m1_resp_valid) begin
                got   = 1'b1;
                act_m = bus.m1_resp_valid ? 1 : 0;
                exp_d = exp_q.pop_front();
                exp_m = exp_m_q.pop_front();
                chk($sformatf("v%0d_resp_master", idx), 64'(act_m), 64'(exp_m));
                chk($sformatf("v%0d_resp_both", idx), 64'(bus.m0_resp_valid & bus.m1_resp_valid), 64'd0);
                chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(3 + v.rdy_dly + v.resp_dly));
                chk($sformatf("v%0d_resp_err", idx), 64'(bus.m0_resp_err | bus.m1_resp_err), 64'd0);
                if (!(exp_m == 1 && v.wen)) begin
                    chk($sformatf("v%0d_rdata", idx),
                        64'((exp_m == 0) ? bus.m0_rdata : bus.m1_rdata), 64'(exp_d));
                end
                if (exp_m == 0) last_m0_rdata = exp_d;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) chk($sformatf("v%0d_resp_seen", idx), 64'd0, 64'd1);
        @(negedge clk);
        chk($sformatf("v%0d_resp_one_pulse", idx), 64'(bus.m0_resp_valid | bus.m1_resp_valid), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int order[4];
        int ngr;
        int nresp;
        int overlap;
        bit hs_pending;

        checks = 0;
        errors = 0;
        last_m0_rdata = '0;
        rst = 1'b0;
        bus.m0_req_valid = 1'b0; bus.m0_addr = '0;
        bus.m1_req_valid = 1'b0; bus.m1_wen = 1'b0; bus.m1_len = '0;
        bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;

        vecs[0] = '{0, 1'b0, 3'd4, 32'h8000_0000, 32'h0,        32'h0000_0413, 0, 0};
        vecs[1] = '{1, 1'b1, 3'd1, 32'h8000_1003, 32'h0000_00AB, 32'h5555_AAAA, 3, 0};
        vecs[2] = '{1, 1'b0, 3'd4, 32'h8000_2000, 32'h0,        32'hDEAD_BEEF, 1, 2};
        vecs[3] = '{1, 1'b0, 3'd2, 32'h8000_2002, 32'h0,        32'h0000_BEEF, 0, 0};
        vecs[4] = '{0, 1'b0, 3'd4, 32'h8000_0004, 32'h0,        $urandom,      2, 1};
        vecs[5] = '{1, 1'b1, 3'd2, 32'h8000_3000, $urandom,     $urandom,      0, 3};

        // Reset state.
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;

        // Vector table.
        for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);
        chk("m0_rdata_hold", 64'(bus.m0_rdata), 64'(last_m0_rdata));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        // Round robin from reset with both requesters held.
        rst = 1'b0;
        bus.m0_req_valid = 1'b1;
        bus.m0_addr      = 32'h8000_0100;
        bus.m1_req_valid = 1'b1;
        bus.m1_wen       = 1'b0;
        bus.m1_len       = 3'd4;
        bus.m1_addr      = 32'h8000_0200;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_ready_in_reset", 64'(bus.m0_req_ready | bus.m1_req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ngr = 0; nresp = 0; overlap = 0; hs_pending = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ngr >= 4) begin
                bus.m0_req_valid = 1'b0;
                bus.m1_req_valid = 1'b0;
            end
            #1;
            if ((bus.m0_resp_valid | bus.m1_resp_valid) && (bus.m0_req_ready | bus.m1_req_ready)) overlap++;
            if (bus.m0_resp_valid | bus.m1_resp_valid) nresp++;
            if (bus.m0_req_ready && ngr < 4) begin order[ngr] = 0; ngr++; end
            if (bus.m1_req_ready && ngr < 4) begin order[ngr] = 1; ngr++; end
            bus.mem_resp_valid = hs_pending;
            bus.mem_rdata      = $urandom;
            hs_pending         = bus.mem_req_valid;
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        chk("rr_grant_count", 64'(ngr), 64'd4);
        for (int g = 0; g < 4; g++) begin
            if (g < ngr) chk($sformatf("rr_grant%0d", g), 64'(order[g]), 64'((g % 2 == 0) ? 1 : 0));
        end
        chk("rr_resp_count", 64'(nresp), 64'd4);
        chk("rr_no_grant_on_resp", 64'(overlap), 64'd0);

        // Reset while waiting for the memory response.
        @(negedge clk);
        bus.m1_req_valid = 1'b1;
        bus.m1_wen       = 1'b0;
        bus.m1_len       = 3'd4;
        bus.m1_addr      = 32'h8000_0300;
        #1;
        chk("rw_accept", 64'(bus.m1_req_ready), 64'd1);
        @(negedge clk);
        bus.m1_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        chk("rw_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        rst = 1'b0;
        #1;
        chk_outputs_zero("rw_reset");
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.m0_resp_valid | bus.m1_resp_valid) nresp++;
            @(negedge clk);
        end
        chk("rw_no_resp", 64'(nresp), 64'd0);
        chk_outputs_zero("rw_after");

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory accepts but never answers: watchdog ends the transaction.
        begin
            bit got;
            int cyc;
            bus.m1_req_valid = 1'b1;
            bus.m1_wen       = 1'b0;
            bus.m1_len       = 3'd4;
            bus.m1_addr      = 32'h8000_0400;
            #1;
            chk("to_accept", 64'(bus.m1_req_ready), 64'd1);
            @(negedge clk);
            bus.m1_req_valid  = 1'b0;
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            cyc = 2;
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                #1;
                if (bus.m1_resp_valid) begin
                    got = 1'b1;
                    chk("to_latency", 64'(cyc), 64'd9);
                    chk("to_err", 64'(bus.m1_resp_err), 64'd1);
                    chk("to_rdata", 64'(bus.m1_rdata), 64'd0);
                    chk("to_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
            if (!got) chk("to_resp_seen", 64'd0, 64'd1);
            run_txn(10, '{1, 1'b0, 3'd4, 32'h8000_0500, 32'h0, 32'hCAFE_F00D, 0, 1});
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
